// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state encoding
// and the quotient returned on a zero divisor.
package div_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Sliced down to the divider width; supports widths up to MaxWidth.
  localparam int unsigned        MaxWidth    = 64;
  localparam logic [MaxWidth-1:0] DivZeroQuot = '1;

endpackage

// File: rtl/cla_sub.sv
// Carry-lookahead subtractor: diff = a + ~b + 1, carry out high means a >= b.
// Lookahead within 4-bit blocks, block carries chained between blocks.
module cla_sub #(
  parameter int unsigned Width = 33
) (
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  output logic [Width-1:0] diff_o,
  output logic             carry_o
);

  localparam int unsigned Blk = 4;

  logic [Width-1:0] g;
  logic [Width-1:0] p;
  logic [Width:0]   c;

  assign g = a_i & ~b_i;
  assign p = a_i ^ ~b_i;

  always_comb begin
    int unsigned base;
    logic        acc;
    logic        pp;
    c    = '0;
    c[0] = 1'b1;
    base = 0;
    acc  = 1'b0;
    pp   = 1'b0;
    for (int unsigned i = 0; i < Width; i++) begin
      base = (i / Blk) * Blk;
      acc  = g[i];
      pp   = p[i];
      // Expand generate/propagate terms back to the block carry-in.
      for (int j = int'(i) - 1; j >= int'(base); j--) begin
        acc = acc | (pp & g[j]);
        pp  = pp & p[j];
      end
      c[i+1] = acc | (pp & c[base]);
    end
  end

  assign diff_o  = p ^ c[Width-1:0];
  assign carry_o = c[Width];

endmodule

// File: rtl/seq_div_32.sv
// Unsigned restoring divider, one quotient bit per clock, with RISC-V style
// divide-by-zero results (quotient all ones, remainder = dividend).
module seq_div_32
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  state_e          state_q;
  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvsr_q;
  logic [CntW-1:0]  cnt_q;
  logic             busy_q;
  logic             done_q;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             no_borrow;
  logic             unused_rem_msb;

  // quo_q doubles as the dividend shift register: its MSB feeds the remainder.
  assign shifted = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};

  cla_sub #(
    .Width(WIDTH + 1)
  ) u_cla_sub (
    .a_i    (shifted),
    .b_i    ({1'b0, dvsr_q}),
    .diff_o (diff),
    .carry_o(no_borrow)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      rem_q   <= '0;
      quo_q   <= '0;
      dvsr_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            dvsr_q <= divisor;
            cnt_q  <= '0;
            if (divisor == '0) begin
              quo_q   <= DivZeroQuot[WIDTH-1:0];
              rem_q   <= {1'b0, dividend};
              state_q <= StDone;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              quo_q   <= dividend;
              rem_q   <= '0;
              state_q <= StRun;
              busy_q  <= 1'b1;
            end
          end else begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          rem_q <= no_borrow ? diff : shifted;
          quo_q <= {quo_q[WIDTH-2:0], no_borrow};
          if (cnt_q == CntW'(WIDTH - 1)) begin
            state_q <= StDone;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // The kept remainder is always below the divisor, so its top bit stays zero.
  assign unused_rem_msb = rem_q[WIDTH];

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rem_q[WIDTH-1:0];

endmodule
